// File: rtl/zion_rr_reg_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin register arbiter.
//   state_e    : arbiter state (IDLE / LOCKED)
//   ptr_width  : bits needed to index n requesters (at least 1)
//   cnt_width  : bits needed to hold a beat count 0..max_burst
package zion_rr_reg_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/zion_rr_picker.sv
// Combinational rotating-priority picker.
//   req_i : request vector
//   ptr_i : index with highest priority; priority falls off ptr_i+1, ptr_i+2, ... (mod N)
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : encoded index of the granted request
//   any_o : at least one request present
module zion_rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Modulo arithmetic keeps this correct for non-power-of-two N.
      j = (32'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PtrW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/zion_rr_reg_arbiter.sv
// Round-robin arbiter sequencing writes from N_REQ requesters into one shared
// clearable, init-valued data register, with optional locked bursts.
//   clk, rst : clock, synchronous active-high reset
//   iClr     : reload INI_DATA and abort any burst (beats every request)
//   iVld     : per-requester data valid
//   iLock    : per-requester request to keep the grant after this beat
//   iDat     : per-requester data
//   oRdy     : one-hot-or-zero grant; transfer when iVld[i] & oRdy[i]
//   oDat     : shared register contents
//   oVld     : pulse, oDat was written by a transfer on the previous edge
//   oBusy    : a locked burst is in progress
module zion_rr_reg_arbiter
  import zion_rr_reg_arbiter_pkg::*;
#(
  parameter int unsigned      N_REQ     = 4,
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] INI_DATA  = WIDTH'(1),
  parameter int unsigned      MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iClr,
  input  logic [N_REQ-1:0]            iVld,
  input  logic [N_REQ-1:0]            iLock,
  input  logic [N_REQ-1:0][WIDTH-1:0] iDat,
  output logic [N_REQ-1:0]            oRdy,
  output logic [WIDTH-1:0]            oDat,
  output logic                        oVld,
  output logic                        oBusy
);

  localparam int unsigned PtrW = ptr_width(N_REQ);
  localparam int unsigned CntW = cnt_width(MAX_BURST);

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dat_q, dat_d;
  logic              vld_q, vld_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PtrW-1:0]   pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  rdy;
  logic              last_beat;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] idx);
    if (32'(idx) == N_REQ - 1) return '0;
    return idx + PtrW'(1);
  endfunction

  zion_rr_picker #(
    .N    (N_REQ),
    .PtrW (PtrW)
  ) u_picker (
    .req_i (iVld),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grant: nothing under reset or clear; picker result in IDLE; owner only in LOCKED.
  always_comb begin
    rdy = '0;
    if (!rst && !iClr) begin
      if (state_q == IDLE) begin
        rdy = pick_gnt;
      end else begin
        rdy[owner_q] = iVld[owner_q];
      end
    end
  end

  assign oRdy = rdy;

  // Burst ends on an unlocked beat or when this beat would reach MAX_BURST.
  assign last_beat = !iLock[owner_q] || ((32'(cnt_q) + 32'd1) >= MAX_BURST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    if (iClr) begin
      state_d = IDLE;
      cnt_d   = '0;
      dat_d   = INI_DATA;
    end else if (state_q == IDLE) begin
      if (pick_any) begin
        dat_d = iDat[pick_idx];
        vld_d = 1'b1;
        if (iLock[pick_idx] && (MAX_BURST > 1)) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          cnt_d   = CntW'(1);
        end else begin
          ptr_d = wrap_inc(pick_idx);
        end
      end
    end else begin
      if (iVld[owner_q]) begin
        dat_d = iDat[owner_q];
        vld_d = 1'b1;
        if (last_beat) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = wrap_inc(owner_q);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (!iLock[owner_q]) begin
        // Owner gave up without sending; stall cycles never count as beats.
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = wrap_inc(owner_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      dat_q   <= INI_DATA;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
    end
  end

  assign oDat  = dat_q;
  assign oVld  = vld_q;
  assign oBusy = (state_q == LOCKED);

endmodule

// File: tb/tb_zion_rr_reg_arbiter.sv
// Self-checking bench for zion_rr_reg_arbiter: directed vector table followed by
// randomized traffic checked against a behavioural model.
module tb_zion_rr_reg_arbiter;

  localparam int          NR  = 4;
  localparam int          MB  = 4;
  localparam logic [31:0] INI = 32'h1;

  logic              clk;
  logic              d_rst, d_clr;
  logic [NR-1:0]     d_vld, d_lock;
  logic [NR-1:0][31:0] d_dat;
  logic [NR-1:0]     oRdy;
  logic [31:0]       oDat;
  logic              oVld, oBusy;

  int n_cmp = 0;
  int n_bad = 0;

  zion_rr_reg_arbiter #(
    .N_REQ     (NR),
    .WIDTH     (32),
    .INI_DATA  (INI),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst   (d_rst),
    .iClr  (d_clr),
    .iVld  (d_vld),
    .iLock (d_lock),
    .iDat  (d_dat),
    .oRdy  (oRdy),
    .oDat  (oDat),
    .oVld  (oVld),
    .oBusy (oBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: whose turn it is, whether a burst is open and how many beats it used.
  int          m_ptr, m_owner, m_beats;
  bit          m_locked;
  logic [31:0] m_dat;
  bit          m_vld;
  int          n_ptr, n_owner, n_beats;
  bit          n_locked;
  logic [31:0] n_dat;
  bit          n_vld;
  logic [NR-1:0] m_rdy;

  task automatic model_eval();
    int w;
    n_ptr = m_ptr; n_owner = m_owner; n_beats = m_beats; n_locked = m_locked;
    n_dat = m_dat; n_vld = 1'b0; m_rdy = '0; w = -1;
    if (d_rst) begin
      n_ptr = 0; n_owner = 0; n_beats = 0; n_locked = 0; n_dat = INI;
    end else if (d_clr) begin
      n_locked = 0; n_beats = 0; n_dat = INI;
    end else if (!m_locked) begin
      for (int k = 0; k < NR; k++)
        if (w < 0 && d_vld[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      if (w >= 0) begin
        m_rdy[w] = 1'b1;
        n_dat    = d_dat[w];
        n_vld    = 1'b1;
        if (d_lock[w] && MB > 1) begin
          n_locked = 1; n_owner = w; n_beats = 1;
        end else begin
          n_ptr = (w + 1) % NR;
        end
      end
    end else if (d_vld[m_owner]) begin
      m_rdy[m_owner] = 1'b1;
      n_dat   = d_dat[m_owner];
      n_vld   = 1'b1;
      n_beats = m_beats + 1;
      if (!d_lock[m_owner] || n_beats == MB) begin
        n_locked = 0; n_beats = 0; n_ptr = (m_owner + 1) % NR;
      end
    end else if (!d_lock[m_owner]) begin
      n_locked = 0; n_beats = 0; n_ptr = (m_owner + 1) % NR;
    end
  endtask

  // One clock cycle: inputs already driven; checks oRdy mid-cycle, registers after the edge.
  task automatic run_cycle(input logic [NR-1:0] e_rdy, input logic [31:0] e_dat,
                           input logic e_vld, input logic e_busy, input bit use_model,
                           input string tag);
    logic [NR-1:0] xr;
    logic [31:0]   xd;
    logic          xv, xb;
    model_eval();
    xr = use_model ? m_rdy : e_rdy;
    #3;
    n_cmp++;
    if (oRdy !== xr) begin
      n_bad++;
      $display("FAIL %s oRdy: got %b want %b", tag, oRdy, xr);
    end
    @(posedge clk);
    m_ptr = n_ptr; m_owner = n_owner; m_beats = n_beats; m_locked = n_locked;
    m_dat = n_dat; m_vld = n_vld;
    xd = use_model ? m_dat : e_dat;
    xv = use_model ? m_vld : e_vld;
    xb = use_model ? m_locked : e_busy;
    #1;
    n_cmp++;
    if (oDat !== xd) begin
      n_bad++;
      $display("FAIL %s oDat: got %h want %h", tag, oDat, xd);
    end
    n_cmp++;
    if (oVld !== xv) begin
      n_bad++;
      $display("FAIL %s oVld: got %b want %b", tag, oVld, xv);
    end
    n_cmp++;
    if (oBusy !== xb) begin
      n_bad++;
      $display("FAIL %s oBusy: got %b want %b", tag, oBusy, xb);
    end
  endtask

  typedef struct {
    logic          rst, clr;
    logic [NR-1:0] vld, lock, rdy;
    logic [31:0]   dat;
    logic          ovld, busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [NR-1:0] v,
                     input logic [NR-1:0] l, input logic [NR-1:0] rd, input logic [31:0] dt,
                     input logic ov, input logic bz, input int reps);
    vec_t t;
    t.rst = r; t.clr = c; t.vld = v; t.lock = l; t.rdy = rd; t.dat = dt; t.ovld = ov; t.busy = bz;
    for (int i = 0; i < reps; i++) vecs.push_back(t);
  endtask

  initial begin
    d_rst = 1'b1; d_clr = 1'b0; d_vld = '0; d_lock = '0;
    for (int i = 0; i < NR; i++) d_dat[i] = 32'hA0 + i;
    m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 0; m_dat = INI; m_vld = 0;

    //   rst clr vld      lock     rdy      dat    ovld busy reps
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, INI,   0, 0, 2);
    add(1, 1, 4'b1111, 4'b1111, 4'b0000, INI,   0, 0, 1);   // rst beats clear
    add(0, 0, 4'b0000, 4'b0000, 4'b0000, INI,   0, 0, 5);   // idle
    // plain round robin over 0..2
    add(0, 0, 4'b0111, 4'b0000, 4'b0001, 'hA0,  1, 0, 1);
    add(0, 0, 4'b0111, 4'b0000, 4'b0010, 'hA1,  1, 0, 1);
    add(0, 0, 4'b0111, 4'b0000, 4'b0100, 'hA2,  1, 0, 1);
    add(0, 0, 4'b0111, 4'b0000, 4'b0001, 'hA0,  1, 0, 1);
    add(0, 0, 4'b0111, 4'b0000, 4'b0010, 'hA1,  1, 0, 1);
    add(0, 0, 4'b0111, 4'b0000, 4'b0100, 'hA2,  1, 0, 1);
    add(0, 0, 4'b0001, 4'b0000, 4'b0001, 'hA0,  1, 0, 1);   // ptr -> 1
    // locked burst from 1 capped at MAX_BURST, then 0 gets its turn
    add(0, 0, 4'b0011, 4'b0010, 4'b0010, 'hA1,  1, 1, 3);
    add(0, 0, 4'b0011, 4'b0010, 4'b0010, 'hA1,  1, 0, 1);
    add(0, 0, 4'b0011, 4'b0010, 4'b0001, 'hA0,  1, 0, 1);
    add(0, 0, 4'b0011, 4'b0010, 4'b0010, 'hA1,  1, 1, 1);
    add(0, 0, 4'b0010, 4'b0000, 4'b0010, 'hA1,  1, 0, 1);   // unlocked last beat, ptr -> 2
    // owner 2 stalls 3 cycles; stalls do not count as beats
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 'hA2,  1, 1, 1);
    add(0, 0, 4'b0000, 4'b0100, 4'b0000, 'hA2,  0, 1, 3);
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 'hA2,  1, 1, 2);
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 'hA2,  1, 0, 1);   // ptr -> 3
    // clear aborts burst from 3; ptr stays 3
    add(0, 0, 4'b1000, 4'b1000, 4'b1000, 'hA3,  1, 1, 1);
    add(0, 1, 4'b1000, 4'b1000, 4'b0000, INI,   0, 0, 1);
    add(0, 0, 4'b1001, 4'b0000, 4'b1000, 'hA3,  1, 0, 1);   // ptr -> 0
    // clear with a request in IDLE
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, INI,   0, 0, 1);
    add(0, 0, 4'b0001, 4'b0000, 4'b0001, 'hA0,  1, 0, 1);
    // owner releases without a transfer
    add(0, 0, 4'b0110, 4'b0110, 4'b0010, 'hA1,  1, 1, 1);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 'hA1,  0, 0, 1);   // ptr -> 2
    add(0, 0, 4'b0110, 4'b0000, 4'b0100, 'hA2,  1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      d_rst = vecs[i].rst; d_clr = vecs[i].clr; d_vld = vecs[i].vld; d_lock = vecs[i].lock;
      run_cycle(vecs[i].rdy, vecs[i].dat, vecs[i].ovld, vecs[i].busy, 1'b0,
                $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 500; i++) begin
      d_rst  = ($urandom_range(0, 79) == 0);
      d_clr  = ($urandom_range(0, 15) == 0);
      d_vld  = NR'($urandom);
      d_lock = NR'($urandom) | NR'($urandom);
      for (int r = 0; r < NR; r++) d_dat[r] = $urandom;
      run_cycle('0, '0, 1'b0, 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
